// File: rtl/recon_pkg.sv
// Shared signed-digit encodings and serializer state constants for the
// reconstruction datapath (digit_serializer producer, adder_array consumer).
package recon_pkg;

  typedef logic [1:0] sd_digit_t;

  // Signed digit {pos,neg}; 2'b11 is never produced.
  localparam sd_digit_t SD_POS  = 2'b10;
  localparam sd_digit_t SD_NEG  = 2'b01;
  localparam sd_digit_t SD_ZERO = 2'b00;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  // The MSB carries negative weight in two's complement, so it maps to -1.
  function automatic sd_digit_t sd_from_bit(input logic b, input logic is_msb);
    sd_digit_t d;
    d = SD_ZERO;
    if (b) begin
      d = is_msb ? SD_NEG : SD_POS;
    end
    return d;
  endfunction

  // Numeric value of a digit, for decoders such as adder_array.
  function automatic logic signed [1:0] sd_value(input sd_digit_t d);
    logic signed [1:0] v;
    v = 2'sd0;
    if (d == SD_POS) begin
      v = 2'sd1;
    end else if (d == SD_NEG) begin
      v = -2'sd1;
    end
    return v;
  endfunction

endpackage

// File: rtl/digit_serializer_sd_encode.sv
// Combinational bit-to-signed-digit recoder used by digit_serializer.
module sd_encode
  import recon_pkg::*;
(
  input  logic       bit_i,
  input  logic       is_msb_i,
  output logic [1:0] digit_o
);

  always_comb begin
    digit_o = sd_from_bit(bit_i, is_msb_i);
  end

endmodule

// File: rtl/digit_serializer.sv
// Streams a two's-complement operand MSB-first as signed digits with a
// valid/ready handshake; back-to-back operands load with no bubble cycle.
module digit_serializer
  import recon_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int IDXW  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] x_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [1:0]       dig_o,
  output logic             dig_valid,
  input  logic             dig_ready,
  output logic             dig_last,
  output logic [IDXW-1:0]  j
);

  localparam logic [IDXW-1:0] J_LAST = IDXW'(WIDTH - 1);

  logic [0:0]       state_q, state_d;
  logic [IDXW-1:0]  j_q, j_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [1:0]       enc_digit;
  logic             consume;
  logic             accept;

  assign dig_valid = (state_q == ST_SEND);
  assign dig_last  = dig_valid && (j_q == J_LAST);
  assign consume   = dig_valid && dig_ready;
  assign in_ready  = !dig_valid || (dig_last && dig_ready);
  assign accept    = in_ready && in_valid;
  assign j         = j_q;

  // The register shifts left per digit, so the current digit is always the MSB.
  sd_encode u_sd_encode (
    .bit_i    (sr_q[WIDTH-1]),
    .is_msb_i (j_q == '0),
    .digit_o  (enc_digit)
  );

  assign dig_o = dig_valid ? enc_digit : SD_ZERO;

  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    sr_d    = sr_q;
    if (accept) begin
      state_d = ST_SEND;
      j_d     = '0;
      sr_d    = x_in;
    end else if (consume) begin
      if (dig_last) begin
        state_d = ST_IDLE;
        j_d     = '0;
        sr_d    = '0;
      end else begin
        j_d  = j_q + 1'b1;
        sr_d = {sr_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      j_q     <= '0;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      sr_q    <= sr_d;
    end
  end

endmodule

// File: tb/tb_digit_serializer.sv
// Directed self-checking bench for digit_serializer (WIDTH=16).
module tb_digit_serializer;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] x_in;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  dig_o;
  logic        dig_valid;
  logic        dig_ready;
  logic        dig_last;
  logic [3:0]  j;

  int errors = 0;
  int checks = 0;

  digit_serializer #(.WIDTH(16), .IDXW(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .x_in      (x_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dig_o     (dig_o),
    .dig_valid (dig_valid),
    .dig_ready (dig_ready),
    .dig_last  (dig_last),
    .j         (j)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] exp_digit(input logic [15:0] v, input int k);
    logic b;
    b = v[15-k];
    if (k == 0) return b ? 2'b01 : 2'b00;
    return b ? 2'b10 : 2'b00;
  endfunction

  function automatic int sd_val(input logic [1:0] d);
    if (d == 2'b10) return 1;
    if (d == 2'b01) return -1;
    return 0;
  endfunction

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; dig_ready = 1'b0; x_in = 16'h0;
    #3;
    checks++; if (dig_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", dig_valid); end
    checks++; if (dig_o !== 2'b00) begin errors++; $display("FAIL reset_dig: got %b expected 00", dig_o); end
    checks++; if (dig_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b expected 0", dig_last); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", in_ready); end
    checks++; if (j !== 4'd0) begin errors++; $display("FAIL reset_j: got %0d expected 0", j); end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_operand(input logic [15:0] v);
    int r;
    r = 0;
    x_in = v; in_valid = 1'b1; dig_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1 || dig_valid !== 1'b0) begin errors++; $display("FAIL idle_%h: got ready=%b valid=%b expected 1 0", v, in_ready, dig_valid); end
    tick();
    in_valid = 1'b0; x_in = ~v;
    for (int k = 0; k < 16; k++) begin
      #1;
      checks++; if (dig_valid !== 1'b1 || dig_o !== exp_digit(v, k) || j !== 4'(k))
        begin errors++; $display("FAIL digit_%h_%0d: got v=%b d=%b j=%0d expected 1 %b %0d", v, k, dig_valid, dig_o, j, exp_digit(v, k), k); end
      checks++; if (dig_last !== (k == 15) || in_ready !== (k == 15))
        begin errors++; $display("FAIL last_%h_%0d: got last=%b ready=%b expected %b", v, k, dig_last, in_ready, (k == 15)); end
      r += sd_val(dig_o) * (1 << (15 - k));
      tick();
    end
    #1;
    checks++; if (dig_valid !== 1'b0) begin errors++; $display("FAIL end_%h: got valid=%b expected 0", v, dig_valid); end
    checks++; if (r !== int'($signed(v))) begin errors++; $display("FAIL recon_%h: got %0d expected %0d", v, r, int'($signed(v))); end
  endtask

  task automatic test_back_to_back();
    int r;
    logic [15:0] v;
    r = 0;
    x_in = 16'h1234; in_valid = 1'b1; dig_ready = 1'b1;
    tick();
    for (int c = 0; c < 32; c++) begin
      v = (c < 16) ? 16'h1234 : 16'hFEDC;
      if (c == 15) x_in = 16'hFEDC;
      if (c == 31) in_valid = 1'b0;
      #1;
      checks++; if (dig_valid !== 1'b1 || dig_o !== exp_digit(v, c % 16) || j !== 4'(c % 16))
        begin errors++; $display("FAIL b2b_digit_%0d: got v=%b d=%b j=%0d expected 1 %b %0d", c, dig_valid, dig_o, j, exp_digit(v, c % 16), c % 16); end
      checks++; if (in_ready !== (c == 15 || c == 31))
        begin errors++; $display("FAIL b2b_ready_%0d: got %b expected %b", c, in_ready, (c == 15 || c == 31)); end
      r += sd_val(dig_o) * (1 << (15 - c % 16));
      if (c == 15) begin
        checks++; if (r !== 4660) begin errors++; $display("FAIL b2b_recon_1234: got %0d expected 4660", r); end
        r = 0;
      end
      if (c == 31) begin
        checks++; if (r !== -292) begin errors++; $display("FAIL b2b_recon_fedc: got %0d expected -292", r); end
      end
      tick();
    end
    #1;
    checks++; if (dig_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b expected 0", dig_valid); end
  endtask

  task automatic test_stall();
    int r, k, cyc;
    r = 0; k = 0; cyc = 0;
    x_in = 16'hA5A5; in_valid = 1'b1; dig_ready = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_idle_ready: got %b expected 1", in_ready); end
    tick();
    in_valid = 1'b0; x_in = 16'h0000;
    while (k < 16 && cyc < 200) begin
      dig_ready = (cyc % 3 == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      #1;
      checks++; if (dig_valid !== 1'b1 || j !== 4'(k) || dig_o !== exp_digit(16'hA5A5, k) || dig_last !== (k == 15))
        begin errors++; $display("FAIL stall_%0d: got v=%b j=%0d d=%b last=%b expected 1 %0d %b %b", cyc, dig_valid, j, dig_o, dig_last, k, exp_digit(16'hA5A5, k), (k == 15)); end
      if (dig_ready) begin
        r += sd_val(dig_o) * (1 << (15 - k));
        k++;
      end
      cyc++;
      tick();
    end
    dig_ready = 1'b0;
    #1;
    checks++; if (k !== 16) begin errors++; $display("FAIL stall_timeout: got %0d digits expected 16", k); end
    checks++; if (r !== int'($signed(16'hA5A5))) begin errors++; $display("FAIL stall_recon: got %0d expected %0d", r, int'($signed(16'hA5A5))); end
    checks++; if (dig_valid !== 1'b0) begin errors++; $display("FAIL stall_idle: got %b expected 0", dig_valid); end
  endtask

  task automatic test_reset_mid();
    x_in = 16'hFFFF; in_valid = 1'b1; dig_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    checks++; if (j !== 4'd7 || dig_valid !== 1'b1) begin errors++; $display("FAIL mid_setup: got j=%0d v=%b expected 7 1", j, dig_valid); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (dig_valid !== 1'b0 || dig_o !== 2'b00 || j !== 4'd0 || dig_last !== 1'b0 || in_ready !== 1'b1)
      begin errors++; $display("FAIL mid_reset: got v=%b d=%b j=%0d last=%b ready=%b expected 0 00 0 0 1", dig_valid, dig_o, j, dig_last, in_ready); end
    tick();
    reset = 1'b0;
    tick();
    checks++; if (dig_valid !== 1'b0) begin errors++; $display("FAIL mid_abandon: got %b expected 0", dig_valid); end
    test_operand(16'h0001);
  endtask

  initial begin
    test_reset();
    test_operand(16'hFFFF);
    test_operand(16'h8000);
    test_operand(16'h7FFF);
    test_operand(16'h0000);
    test_back_to_back();
    test_stall();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
